// File: rtl/pci_phy_pkg.sv
// Shared PHY definitions: symbol width, control symbols and the transmitter FSM states.
package pci_phy_pkg;

    localparam int SYM_W = 8;

    localparam logic [SYM_W-1:0] SYM_COM = 8'hBC;
    localparam logic [SYM_W-1:0] SYM_IDL = 8'h7C;

    typedef enum logic {
        SYNC,
        ACTIVE
    } tx_state_t;

endpackage

// File: rtl/slot_counter.sv
// Free-running bit counter marking the symbol slot boundary (bit_cnt == 7).
// Comes out of reset at 7 so the first edge after release starts a symbol.
module slot_counter (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] bit_cnt,
    output logic       boundary
);

    // Wraps 7 -> 0 every cycle; the edge seen while at 7 is a slot boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bit_cnt <= 3'd7;
        else        bit_cnt <= bit_cnt + 3'd1;
    end

    assign boundary = (bit_cnt == 3'd7);

endmodule

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: COM preamble after reset, then user bytes
// MSB-first, one symbol per 8 bit clocks, filler in empty slots.
// Build option: define PS_IDLE_COM_EN to use COM as the filler symbol
// instead of IDL. The preamble is COM either way.
module paralelo_serial_tx
    import pci_phy_pkg::*;
#(
    parameter int N_COM = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [SYM_W-1:0] data_in,
    input  logic             valid_in,
    output logic             ready,
    output logic             data_out,
    output logic             sym_start,
    output logic             active
);

`ifdef PS_IDLE_COM_EN
    localparam logic [SYM_W-1:0] SYM_FILL = SYM_COM;
`else
    localparam logic [SYM_W-1:0] SYM_FILL = SYM_IDL;
`endif

    localparam logic [3:0] LAST_COM = 4'(N_COM - 1);

    logic [2:0]       bit_cnt;
    logic             boundary;
    tx_state_t        state;
    logic [3:0]       com_cnt;
    logic [SYM_W-1:0] hold_reg;
    logic             hold_full;
    logic [SYM_W-1:0] shift_reg;
    logic [SYM_W-1:0] next_sym;
    logic             take;

    slot_counter u_slot (
        .clk      (clk_32f),
        .rst_n    (reset),
        .bit_cnt  (bit_cnt),
        .boundary (boundary)
    );

    // ready comes only from registers; at a boundary the held byte leaves
    // the hold register on the same edge, so a new one can enter
    assign ready = active & (~hold_full | (bit_cnt == 3'd7));
    assign take  = valid_in & ready;

    // Symbol to load at the next boundary
    always_comb begin
        next_sym = SYM_COM;
        if (state == ACTIVE) next_sym = hold_full ? hold_reg : SYM_FILL;
    end

    // Shifter: load a fresh symbol at each boundary, otherwise shift MSB out
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            data_out  <= 1'b0;
            sym_start <= 1'b0;
        end else begin
            sym_start <= boundary;
            if (boundary) begin
                data_out  <= next_sym[SYM_W-1];
                shift_reg <= {next_sym[SYM_W-2:0], 1'b0};
            end else begin
                data_out  <= shift_reg[SYM_W-1];
                shift_reg <= {shift_reg[SYM_W-2:0], 1'b0};
            end
        end
    end

    // Preamble/active FSM plus the one-entry hold register
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            com_cnt   <= '0;
            active    <= 1'b0;
            hold_full <= 1'b0;
            hold_reg  <= '0;
        end else begin
            case (state)
                SYNC: begin
                    if (boundary) begin
                        com_cnt <= com_cnt + 4'd1;
                        if (com_cnt == LAST_COM) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    // At a boundary the hold drains into the shifter; a
                    // transfer on that same edge refills it
                    if (boundary)  hold_full <= take;
                    else if (take) hold_full <= 1'b1;
                    if (take) hold_reg <= data_in;
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx with a slot-indexed scoreboard:
// accepted bytes are queued with the slot they must occupy, and every
// received symbol is compared with COM, the queued byte, or the filler.
module tb_paralelo_serial_tx;

    localparam int N_COM = 4;
    localparam logic [7:0] COM = 8'hBC;
`ifdef PS_IDLE_COM_EN
    localparam logic [7:0] FILL = 8'hBC;
`else
    localparam logic [7:0] FILL = 8'h7C;
`endif

    typedef struct {
        logic [7:0] sym;
        int         slot;
    } exp_t;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready;
    logic       data_out;
    logic       sym_start;
    logic       active;

    paralelo_serial_tx #(.N_COM(N_COM)) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready     (ready),
        .data_out  (data_out),
        .sym_start (sym_start),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    int         cnt_cmp = 0;
    int         cnt_bad = 0;
    exp_t       sbq[$];
    logic [2:0] m_cnt;
    int         m_slot;
    int         last_slot;
    logic [7:0] mon_sh;
    int         mon_n;
    int         mon_slot;
    logic       last_acc;
    logic [2:0] last_acc_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cnt_cmp++;
        assert (obs === exp) else begin
            cnt_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_model();
        m_cnt     = 3'd7;
        m_slot    = 0;
        last_slot = 0;
        sbq.delete();
        mon_n     = 0;
        mon_slot  = 0;
        mon_sh    = '0;
    endtask

    task automatic check_symbol();
        logic [7:0] exp;
        exp = FILL;
        chk("slot_align", mon_slot, m_slot);
        if (mon_slot <= N_COM) exp = COM;
        else begin
            while (sbq.size() > 0 && sbq[0].slot < mon_slot) begin
                chk("lost_byte_slot", sbq[0].slot, mon_slot);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].slot == mon_slot) begin
                exp = sbq[0].sym;
                void'(sbq.pop_front());
            end
        end
        chk("symbol", mon_sh, exp);
    endtask

    task automatic check_outputs();
        logic hold;
        hold = 1'b0;
        foreach (sbq[i]) if (sbq[i].slot > m_slot) hold = 1'b1;
        chk("sym_start", sym_start, m_cnt == 3'd0);
        chk("active", active, m_slot >= N_COM);
        chk("ready", ready, (m_slot >= N_COM) && (!hold || m_cnt == 3'd7));
        if (sym_start) begin
            mon_sh = {7'b0, data_out};
            mon_n  = 1;
            mon_slot++;
        end else if (mon_n > 0) begin
            mon_sh = {mon_sh[6:0], data_out};
            mon_n++;
        end
        if (mon_n == 8) begin
            check_symbol();
            mon_n = 0;
        end
    endtask

    // One bit clock: sample the handshake before the edge, advance the
    // model across the edge, check outputs on the falling edge.
    task automatic tick();
        logic       acc;
        logic       bnd;
        logic [7:0] d;
        int         tgt;
        acc = valid_in && ready;
        bnd = (m_cnt == 3'd7);
        d   = data_in;
        last_acc     = acc;
        last_acc_cnt = m_cnt;
        @(posedge clk_32f);
        if (bnd) m_slot++;
        if (acc) begin
            tgt = m_slot + 1;
            if (tgt <= last_slot) tgt = last_slot + 1;
            sbq.push_back('{d, tgt});
            last_slot = tgt;
        end
        m_cnt = m_cnt + 3'd1;
        @(negedge clk_32f);
        check_outputs();
    endtask

    task automatic wait_cnt(input logic [2:0] k);
        int n;
        n = 0;
        while (m_cnt != k && n < 16) begin tick(); n++; end
        chk("align_bit_cnt", m_cnt, k);
    endtask

    task automatic send(input logic [7:0] b, output int slot);
        int n;
        data_in  = b;
        valid_in = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!last_acc && n < 40);
        chk("accepted", last_acc, 1'b1);
        slot = last_slot;
    endtask

    initial begin
        int s0, s1, s2, n;
        logic [7:0] bytes [3];
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        clr_model();
        #2;
        chk("rst_data_out", data_out, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_sym_start", sym_start, 1'b0);
        chk("rst_active", active, 1'b0);

        // Preamble then idle fillers; valid_in must be ignored in the preamble
        @(negedge clk_32f);
        reset = 1'b1;
        repeat (10) tick();
        data_in = 8'h55; valid_in = 1'b1;
        repeat (5) tick();
        valid_in = 1'b0;
        repeat (17) tick();
        chk("active_after_preamble", active, 1'b1);
        repeat (24) tick();

        // Single byte offered at bit_cnt=2: 5-cycle latency
        wait_cnt(3'd2);
        data_in = 8'hF0; valid_in = 1'b1;
        tick();
        chk("accept_f0_same_cycle", last_acc, 1'b1);
        valid_in = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!sym_start && n < 20);
        chk("latency_f0", n, 5);
        chk("f0_first_bit", data_out, 1'b1);
        repeat (16) tick();

        // Back-to-back bytes with valid_in held high: no filler between them
        bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hA5;
        send(bytes[0], s0);
        send(bytes[1], s1);
        send(bytes[2], s2);
        valid_in = 1'b0;
        chk("gapless_1", s1 - s0, 1);
        chk("gapless_2", s2 - s1, 1);
        repeat (32) tick();

        // Transfer at a boundary while the hold register is full
        wait_cnt(3'd3);
        send(8'h5A, s0);
        send(8'hC3, s1);
        valid_in = 1'b0;
        chk("transfer_at_boundary", last_acc_cnt, 3'd7);
        chk("held_then_new", s1 - s0, 1);
        repeat (24) tick();

        // Reset 3 bits into 0xF0: line drops, preamble restarts, byte not resent
        wait_cnt(3'd2);
        send(8'hF0, s0);
        valid_in = 1'b0;
        n = 0;
        while (!(mon_slot == s0 && mon_n == 3) && n < 40) begin tick(); n++; end
        chk("reached_mid_symbol", mon_n, 3);
        reset = 1'b0;
        #1;
        chk("rst_mid_data_out", data_out, 1'b0);
        chk("rst_mid_active", active, 1'b0);
        chk("rst_mid_ready", ready, 1'b0);
        clr_model();
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
        repeat (32 + 24) tick();
        chk("drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_tx.md
# paralelo_serial_tx

Parallel-to-serial transmitter for the PCIe-style physical layer: accepts 8-bit symbols over a valid/ready handshake and drives them MSB-first on a 1-bit line at the bit rate, one symbol per 8 bit clocks. It is the transmit-side counterpart of the serial-to-parallel receiver. After reset it emits a COM (0xBC) preamble so the receiver can align, then carries user bytes, inserting a filler symbol in any slot with no byte queued.

## Interface
- N_COM, 4, number of COM symbols sent after reset before user data is accepted (1..15)
- clk_32f  input  1  bit clock; all state on its rising edge
- reset  input  1  asynchronous, active-low reset
- data_in  input  8  parallel byte to transmit
- valid_in  input  1  data_in is valid this cycle
- ready  output  1  block accepts data_in this cycle (transfer when valid_in & ready)
- data_out  output  1  serial line, MSB first
- sym_start  output  1  one-cycle pulse while bit 7 of a symbol is on data_out
- active  output  1  preamble finished; user data accepted

## Operation
- bit_cnt: 3-bit counter, wraps 7->0 every cycle; an edge with bit_cnt==7 is a slot boundary.
- Hold register (1 entry, hold_full flag) between handshake and shifter.
- Shifter: 8-bit shift_reg. At a slot boundary: data_out <= next_sym[7], shift_reg <= {next_sym[6:0],1'b0}. Otherwise: data_out <= shift_reg[7], shift_reg <= shift_reg<<1.
- FSM states:
  - SYNC: next_sym = COM (0xBC); com_cnt increments per boundary; on the boundary that loads the N_COM-th COM, go to ACTIVE. ready=0.
  - ACTIVE: next_sym = hold if hold_full (hold_full clears), else the filler symbol. ready = !hold_full | (bit_cnt==7).
- Transfer while hold_full at a boundary: the held byte loads into the shifter and the new byte enters hold on the same edge; no loss or duplication.
- valid_in while ready=0 is ignored; the source holds data_in/valid_in until transfer.
- Max throughput: one byte per 8 cycles; sustained valid_in gives gap-free user symbols.
- ready is built only from registers; no combinational path from valid_in.
- Reset: asynchronous, active-low; the current symbol is truncated, FSM returns to SYNC, and the preamble restarts in full after release.

## Timing
- Reset values: bit_cnt=7, shift_reg=0, data_out=0, hold_full=0, com_cnt=0, state=SYNC, ready=0, sym_start=0, active=0.
- First rising edge after release is a boundary: bit 7 of the first COM appears on data_out after that edge.
- sym_start = registered (bit_cnt==7 at previous edge), i.e. high in the cycle data_out carries bit 7.
- active rises in the cycle after the boundary that loads the last preamble COM. ready first asserts in that same cycle.
- Latency: byte accepted at edge E with hold empty and bit_cnt=k (k != 7): its bit 7 appears on data_out after the next boundary edge, 7-k cycles after E. If accepted at a boundary edge with hold empty, it is enqueued and goes out at the following boundary (8 cycles later).
- Serial line: symbol 0xBC appears on data_out as 1,0,1,1,1,1,0,0.

## Configuration
- PS_IDLE_COM_EN defined: the filler symbol in empty ACTIVE slots is COM (0xBC).
- PS_IDLE_COM_EN undefined: the filler symbol is IDL (0x7C).
- The preamble is always COM, regardless of the macro.

## Structure
- Shared package pci_phy_pkg: SYM_COM=8'hBC, SYM_IDL=8'h7C, the FSM state typedef (SYNC, ACTIVE), and the symbol width constant 8.
- One sub-module, slot_counter: the bit_cnt counter with a boundary flag output, reusable by the receiver.
- Hold register, shifter and FSM live in paralelo_serial_tx.

## Test plan
- Release reset with N_COM=4 and valid_in=0. Required: data_out shows 0xBC four times (32 cycles); active=1 after the 4th; ready=0 throughout the preamble.
- After the preamble, no data is offered. Required: the filler repeats, 0xBC with PS_IDLE_COM_EN and 0x7C without; sym_start pulses every 8 cycles.
- Offer 0xF0 at bit_cnt=2. Required: accepted the same cycle; 1,1,1,1,0,0,0,0 starts 5 cycles later, aligned with sym_start.
- Back-to-back 0x01, 0x80, 0xA5 with valid_in held high. Required: three consecutive symbols with no filler between them; ready drops while hold_full and re-asserts at each boundary.
- Transfer at a boundary edge while hold_full. Required: the held byte is transmitted next and the new byte in the following slot.
- Assert reset mid-symbol, 3 bits into 0xF0. Required: data_out=0 immediately; the full N_COM preamble restarts after release; the truncated byte is never resent.
